alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the datapath ALU; same ALUControl encoding.
- Single-cycle ADD/SUB/AND/ORR/EOR, plus the multiply ops MUL/UMULL/SMULL implemented as an iterative shift-add multiplier.
- Sits in the execute stage of the multi-cycle core.
- The controller issues `start` and waits for `done`; results and flags are registered and held until the next accepted `start`.

Parameters:
- WIDTH, 32: operand/result width. Legal values are ≥4 and a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1: multiplier bits retired per iteration (1, 2 or 4). N = WIDTH/BITS_PER_CYCLE iterations.

Ports:
- clk: input, 1. Single clock, rising edge.
- reset: input, 1. Synchronous, active-high.
- start: input, 1. Operation request, sampled on a clk edge when the block can accept.
- a: input, WIDTH. Operand A, latched on an accepted start.
- b: input, WIDTH. Operand B, latched on an accepted start.
- ALUControl: input, 3. 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 UMULL, 111 SMULL.
- busy: output, 1. High while a multiply is in progress.
- done: output, 1. One-cycle pulse; Result/Result2/ALUFlags are valid from this cycle onward.
- Result: output, WIDTH. Primary result, or the low half of a long multiply.
- Result2: output, WIDTH. High half of UMULL/SMULL; 0 for all other ops.
- ALUFlags: output, 4. {N,Z,C,V}.

Behaviour:
- Reset: state=IDLE; busy, done, Result, Result2, ALUFlags all 0. Reset during a multiply aborts it; no done is generated.
- States: IDLE, MUL, FIX.
- Accept: start is accepted when state=IDLE (done may be high in that cycle, so back-to-back is allowed). start in MUL/FIX is ignored. Operands and op are captured at acceptance; later changes to a/b/ALUControl have no effect.
- ADD/SUB/logic ops, latency 1:
  - Result is registered on the accepting edge; done=1 the following cycle; state stays IDLE.
  - ADD: a+b. SUB: a+~b+1.
  - C = carry out of the WIDTH-bit sum (SUB: C=1 means no borrow).
  - V = signed overflow.
  - AND/ORR/EOR: C=0, V=0.
  - N = Result[WIDTH-1]; Z = (Result==0).
- Multiply path:
  - On accept, go to MUL; busy=1.
  - UMULL/MUL: use the raw operands.
  - SMULL: latch |a|, |b| as unsigned WIDTH-bit values, where |−2^(WIDTH−1)| = 2^(WIDTH−1) with no overflow. Record neg = a[MSB]^b[MSB].
  - MUL: N edges, each retiring BITS_PER_CYCLE multiplier bits into a 2·WIDTH accumulator. Next state is FIX after iteration N.
  - FIX: one edge. For SMULL with neg=1, the 2·WIDTH product is two's-complement negated; otherwise it passes through unchanged. Outputs are written, done=1 the next cycle, busy=0, state returns to IDLE.
  - Start-to-done latency: N+1 edges. busy is high for exactly N+1 cycles.
- Multiply outputs:
  - MUL: Result = low WIDTH bits of the product; Result2 = 0. The upper half is discarded and no overflow indication is given.
  - UMULL/SMULL: {Result2,Result} = full 2·WIDTH product.
- Multiply flags:
  - N = MSB of the final result: Result[MSB] for MUL, Result2[MSB] for long multiplies.
  - Z = 1 iff all returned product bits are 0.
  - C = 0, V = 0.
- Output hold: outputs are unchanged between done and the next accepted start. During MUL/FIX, outputs hold their previous values.
- Zero operand: no early termination; latency is always N+1.

Test Plan (WIDTH=32, BITS_PER_CYCLE=1 unless stated):
- ADD a=0xFFFFFFFF, b=0x00000001 -> one cycle later done=1, Result=0x00000000, Result2=0, flags N0 Z1 C1 V0; busy never asserts.
- SUB a=0x80000000, b=0x00000001 -> Result=0x7FFFFFFF, flags N0 Z0 C1 V1. EOR a=b=0xA5A5A5A5 -> Result=0, flags N0 Z1 C0 V0.
- UMULL a=b=0xFFFFFFFF -> busy high 33 cycles; done exactly 33 edges after the start edge; Result2=0xFFFFFFFE, Result=0x00000001, N1 Z0 C0 V0.
- SMULL -3×5 -> Result2=0xFFFFFFFF, Result=0xFFFFFFF1, N1. SMULL 0x80000000×0xFFFFFFFF -> Result2=0x00000000, Result=0x80000000, N0.
- MUL 0x00010000×0x00010000 -> Result=0, Result2=0, Z1. Repeat with BITS_PER_CYCLE=4: same result, done 9 edges after start.
- Protocol:
  - start pulsed mid-UMULL with new operands -> ignored; the original result is returned.
  - reset asserted at iteration 10 -> next cycle busy=0, done=0, all outputs 0, and no later done.
  - start asserted during a done cycle -> accepted; the second op completes with correct latency.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle add/sub/logic, iterative shift-add MUL/UMULL/SMULL
module alu_mc #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       ALUControl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result2,
  output logic [3:0]       ALUFlags
);

  localparam int N   = WIDTH / BITS_PER_CYCLE;
  localparam int CW  = $clog2(N + 1);
  localparam int PW  = 2 * WIDTH;
  localparam int MSB = WIDTH - 1;

  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_ORR   = 3'b011;
  localparam logic [2:0] OP_EOR   = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;
  localparam logic [2:0] OP_SMULL = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIX} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     acc;
  logic [PW-1:0]     mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     iter;
  logic [2:0]        op;
  logic              neg;

  logic              accept;
  logic              is_mul;
  logic              last_iter;

  assign accept    = start && (state == S_IDLE);
  assign is_mul    = ALUControl[2] & (ALUControl[1] | ALUControl[0]);
  assign last_iter = (iter == CW'(N - 1));

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && is_mul) state_next = S_MUL;
      end
      S_MUL: begin
        busy = 1'b1;
        if (last_iter) state_next = S_FIX;
      end
      S_FIX: begin
        busy       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // SUB reuses the adder as a + ~b + 1 so C means "no borrow"
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  assign is_sub = (ALUControl == OP_SUB);
  assign b_eff  = is_sub ? ~b : b;
  assign sum    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    alu_res = sum[WIDTH-1:0];
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (ALUControl)
      OP_AND:  alu_res = a & b;
      OP_ORR:  alu_res = a | b;
      OP_EOR:  alu_res = a ^ b;
      default: begin
        alu_c = sum[WIDTH];
        alu_v = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
      end
    endcase
  end

  // SMULL multiplies magnitudes; |-2^(W-1)| is representable as unsigned W bits
  logic             is_smull;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_smull = (ALUControl == OP_SMULL);
  assign a_mag    = (is_smull && a[MSB]) ? -a : a;
  assign b_mag    = (is_smull && b[MSB]) ? -b : b;

  logic [PW-1:0] partial;
  logic [PW-1:0] prod;

  always_comb begin
    partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (mplier[j]) partial = partial + (mcand << j);
    end
  end

  assign prod = neg ? -acc : acc;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done     <= 1'b0;
      Result   <= '0;
      Result2  <= '0;
      ALUFlags <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      iter     <= '0;
      op       <= '0;
      neg      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              op     <= ALUControl;
              acc    <= '0;
              mcand  <= {{WIDTH{1'b0}}, a_mag};
              mplier <= b_mag;
              iter   <= '0;
              neg    <= is_smull && (a[MSB] ^ b[MSB]);
            end else begin
              Result   <= alu_res;
              Result2  <= '0;
              ALUFlags <= {alu_res[MSB], (alu_res == '0), alu_c, alu_v};
              done     <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc    <= acc + partial;
          mcand  <= mcand << BITS_PER_CYCLE;
          mplier <= mplier >> BITS_PER_CYCLE;
          iter   <= iter + CW'(1);
        end
        S_FIX: begin
          done <= 1'b1;
          if (op == OP_MUL) begin
            Result   <= prod[WIDTH-1:0];
            Result2  <= '0;
            ALUFlags <= {prod[MSB], (prod[WIDTH-1:0] == '0), 2'b00};
          end else begin
            Result   <= prod[WIDTH-1:0];
            Result2  <= prod[PW-1:WIDTH];
            ALUFlags <= {prod[PW-1], (prod == '0), 2'b00};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - randomized bench for alu_mc against an arithmetic reference model
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start1 = 1'b0;
  logic        start4 = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0]  ctl = '0;
  logic        busy1, done1, busy4, done4;
  logic [31:0] r1, r1h, r4, r4h;
  logic [3:0]  f1, f4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b), .ALUControl(ctl),
    .busy(busy1), .done(done1), .Result(r1), .Result2(r1h), .ALUFlags(f1)
  );

  alu_mc #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a), .b(b), .ALUControl(ctl),
    .busy(busy4), .done(done4), .Result(r4), .Result2(r4h), .ALUFlags(f4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [31:0] r2, output logic [3:0] f);
    longint      sx, sy, s;
    longint      lim;
    logic [63:0] p;
    logic        c, v, n, z;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    lim = 64'sd2147483648;
    r = '0; r2 = '0; c = 1'b0; v = 1'b0; p = '0;
    case (o)
      3'd0: begin
        r = x + y;
        c = ({32'b0, x} + {32'b0, y}) > 64'hFFFF_FFFF;
        s = sx + sy;
        v = (s >= lim) || (s < -lim);
      end
      3'd1: begin
        r = x - y;
        c = (x >= y);
        s = sx - sy;
        v = (s >= lim) || (s < -lim);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; end
      3'd6: begin p = {32'b0, x} * {32'b0, y}; r = p[31:0]; r2 = p[63:32]; end
      default: begin p = sx * sy; r = p[31:0]; r2 = p[63:32]; end
    endcase
    n = (o >= 3'd6) ? r2[31] : r[31];
    z = (o >= 3'd6) ? ({r2, r} == 64'd0) : (r == 32'd0);
    f = {n, z, c, v};
  endfunction

  // Issue one op; returns while the finishing done is visible, so the next call is back-to-back
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit both, input int poke);
    logic [31:0] er, er2, pr1;
    logic [3:0]  ef;
    int          k, lat1, lat4, bc1, bc4;
    bit          s1, s4, ismul;
    model(o, x, y, er, er2, ef);
    ismul = (o >= 3'd5);
    pr1 = r1;
    a = x; b = y; ctl = o; start1 = 1'b1; start4 = both;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
    k = 0; s1 = 1'b0; s4 = !both; lat1 = -1; lat4 = -1; bc1 = 0; bc4 = 0;
    while (k < 60) begin
      if (!s1) begin
        if (done1) begin s1 = 1'b1; lat1 = k; end
        else if (busy1) bc1++;
      end
      if (!s4) begin
        if (done4) begin s4 = 1'b1; lat4 = k; end
        else if (busy4) bc4++;
      end
      if (s1 && s4) break;
      if (k == 3 && ismul && !s1) check("hold_mid", {32'b0, r1}, {32'b0, pr1});
      if (k == poke) begin
        start1 = 1'b1; a = $urandom; b = $urandom; ctl = 3'($urandom);
      end
      @(posedge clk); #1;
      start1 = 1'b0;
      k++;
    end
    check("lat1", 64'(lat1), ismul ? 64'd33 : 64'd0);
    check("busy1", 64'(bc1), ismul ? 64'd33 : 64'd0);
    check("res1", {r1h, r1}, {er2, er});
    check("flags1", {60'b0, f1}, {60'b0, ef});
    if (both) begin
      check("lat4", 64'(lat4), ismul ? 64'd9 : 64'd0);
      check("busy4", 64'(bc4), ismul ? 64'd9 : 64'd0);
      check("res4", {r4h, r4}, {er2, er});
      check("flags4", {60'b0, f4}, {60'b0, ef});
    end
  endtask

  typedef struct {
    logic [2:0]  o;
    logic [31:0] x;
    logic [31:0] y;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int ndone;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out1", {busy1, done1, f1, r1h, r1}, '0);
    check("rst_out4", {busy4, done4, f4, r4h, r4}, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    vecs.push_back('{3'd0, 32'hFFFF_FFFF, 32'h0000_0001});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h0000_0001});
    vecs.push_back('{3'd4, 32'hA5A5_A5A5, 32'hA5A5_A5A5});
    vecs.push_back('{3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'd7, 32'hFFFF_FFFD, 32'h0000_0005});
    vecs.push_back('{3'd7, 32'h8000_0000, 32'hFFFF_FFFF});
    vecs.push_back('{3'd5, 32'h0001_0000, 32'h0001_0000});
    vecs.push_back('{3'd7, 32'h8000_0000, 32'h8000_0000});
    vecs.push_back('{3'd6, 32'h0000_0000, 32'h1234_5678});
    foreach (vecs[i]) begin
      do_op(vecs[i].o, vecs[i].x, vecs[i].y, 1'b1, -1);
      if (i == 3) begin
        check("umull_ff_res", {r1h, r1}, 64'hFFFF_FFFE_0000_0001);
        check("umull_ff_flags", {60'b0, f1}, 64'h8);
      end
    end

    // start pulsed mid-multiply must be ignored
    do_op(3'd6, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 5);
    check("ignore_start", {r1h, r1}, 64'h1234_5678 * 64'h9ABC_DEF0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] x, y;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      do_op(3'($urandom), x, y, 1'b1, -1);
    end

    // reset while dut1 is at iteration 10 aborts the multiply silently
    a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; ctl = 3'd6; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_abort_busy", {63'b0, busy1}, 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_out1", {busy1, done1, f1, r1h, r1}, '0);
    check("abort_out4", {busy4, done4, f4, r4h, r4}, '0);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done1 || busy1) ndone++;
    end
    check("no_done_after_abort", 64'(ndone), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
